// File: rtl/my_spi_regbank.sv
// Mode-0 SPI slave register bank with burst read/write, address auto-increment and write strobes.
// Define MYSPI_SHADOW_EN to stage writes in a shadow bank that is committed when CS rises.
module my_spi_regbank #(
  parameter int                  DATA_W   = 8,
  parameter int                  NUM_REGS = 8,
  parameter int                  ADDR_W   = 7,
  parameter logic [NUM_REGS-1:0] RO_MASK  = 'b10
) (
  input  logic                         theClock,
  input  logic                         theReset,
  input  logic                         MySPI_clk,
  input  logic                         MySPI_cs,
  input  logic                         MySPI_sdi,
  output logic                         MySPI_sdo,
  input  logic [NUM_REGS*DATA_W-1:0]   Status_in,
  output logic [NUM_REGS*DATA_W-1:0]   Regs_out,
  output logic [NUM_REGS-1:0]          Wr_strobe,
  output logic                         Busy
);

  localparam int CMD_W = 1 + ADDR_W;
  localparam int SR_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic              sck_q1, sck_q2, sck_q3;
  logic              cs_q1, cs_q2, cs_q3;
  logic              sdi_q1, sdi_q2;
  logic              sck_rise, cs_rise, cs_fall, shift_en;
  logic [2:0]        state, state_nxt;
  logic [SR_W-1:0]   sr, sr_shift;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ptr, ptr_inc;
  logic              is_wr;
  logic [DATA_W-1:0] rd_val, wdata;
  logic [NUM_REGS-1:0] wr_sel;

  // CS flops reset low so a frame already in progress at reset release never shows a fall
  always_ff @(posedge theClock) begin
    if (theReset) begin
      {sck_q1, sck_q2, sck_q3} <= 3'b000;
      {cs_q1, cs_q2, cs_q3}    <= 3'b000;
      {sdi_q1, sdi_q2}         <= 2'b00;
    end else begin
      sck_q1 <= MySPI_clk;
      sck_q2 <= sck_q1;
      sck_q3 <= sck_q2;
      cs_q1  <= MySPI_cs;
      cs_q2  <= cs_q1;
      cs_q3  <= cs_q2;
      sdi_q1 <= MySPI_sdi;
      sdi_q2 <= sdi_q1;
    end
  end

  assign sck_rise  = sck_q2 & ~sck_q3;
  assign cs_rise   = cs_q2 & ~cs_q3;
  assign cs_fall   = ~cs_q2 & cs_q3;
  assign shift_en  = sck_rise & ~cs_rise;
  assign sr_shift  = {sr[SR_W-2:0], sdi_q2};
  assign wdata     = sr[DATA_W-1:0];
  assign ptr_inc   = (ptr == ADDR_W'(NUM_REGS - 1)) ? ADDR_W'(0) : ptr + ADDR_W'(1);
  assign MySPI_sdo = sr[SR_W-1];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = cs_fall ? S_CMD : S_IDLE;
      S_CMD:    state_nxt = (shift_en && cnt == CNT_W'(CMD_W - 1)) ? S_LOAD : S_CMD;
      S_LOAD:   state_nxt = S_DATA;
      S_DATA:   state_nxt = (shift_en && cnt == CNT_W'(DATA_W - 1)) ? S_COMMIT : S_DATA;
      S_COMMIT: state_nxt = S_LOAD;
      default:  state_nxt = S_IDLE;
    endcase
    if (cs_rise) begin
      state_nxt = S_IDLE;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // Read mux: RO addresses return status, out-of-range pointers return zero
  always_comb begin
    rd_val = '0;
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val = rd_val | ({DATA_W{ptr == ADDR_W'(i)}} &
               (RO_MASK[i] ? Status_in[i*DATA_W +: DATA_W] : Regs_out[i*DATA_W +: DATA_W]));
      wr_sel[i] = (state == S_COMMIT) && is_wr && (ptr == ADDR_W'(i)) && !RO_MASK[i];
    end
  end

  always_ff @(posedge theClock) begin
    if (theReset) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      ptr   <= '0;
      is_wr <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: cnt <= '0;
        S_CMD: begin
          if (shift_en) begin
            sr  <= sr_shift;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(CMD_W - 1)) begin
              is_wr <= sr_shift[CMD_W-1];
              ptr   <= sr_shift[ADDR_W-1:0];
            end
          end
        end
        S_LOAD: begin
          sr  <= SR_W'(rd_val) << (SR_W - DATA_W);
          cnt <= '0;
        end
        S_DATA: begin
          if (shift_en) begin
            sr  <= sr_shift;
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_COMMIT: ptr <= ptr_inc;
        default: cnt <= '0;
      endcase
    end
  end

`ifdef MYSPI_SHADOW_EN
  logic [NUM_REGS*DATA_W-1:0] shadow;
  logic [NUM_REGS-1:0]        dirty;
  logic                       flush;

  // Idle is only reached through a CS rise (or reset, which clears dirty), so dirty data here means a finished frame
  assign flush = (state == S_IDLE) && (|dirty);

  always_ff @(posedge theClock) begin
    if (theReset) begin
      shadow    <= '0;
      dirty     <= '0;
      Regs_out  <= '0;
      Wr_strobe <= '0;
    end else begin
      Wr_strobe <= flush ? dirty : '0;
      dirty     <= (flush ? '0 : dirty) | wr_sel;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (flush && dirty[i]) begin
          Regs_out[i*DATA_W +: DATA_W] <= shadow[i*DATA_W +: DATA_W];
        end
        if (wr_sel[i]) begin
          shadow[i*DATA_W +: DATA_W] <= wdata;
        end
      end
    end
  end
`else
  // A completed word commits even if CS rises in the same cycle; only partial words are dropped
  always_ff @(posedge theClock) begin
    if (theReset) begin
      Regs_out  <= '0;
      Wr_strobe <= '0;
    end else begin
      Wr_strobe <= wr_sel;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          Regs_out[i*DATA_W +: DATA_W] <= wdata;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_my_spi_regbank.sv
// Self-checking bench for my_spi_regbank (default build): directed test-plan frames plus random frames
// checked against a frame-level register-bank model.
module tb_my_spi_regbank;

  localparam int NR   = 8;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs  = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo;
  logic [63:0] status = 64'h0;
  logic [63:0] regs_out;
  logic [7:0]  strobe;
  logic        busy;

  always #5 clk = ~clk;

  my_spi_regbank #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(7), .RO_MASK(8'b0000_0010)) dut (
    .theClock (clk),
    .theReset (rst),
    .MySPI_clk(sck),
    .MySPI_cs (cs),
    .MySPI_sdi(sdi),
    .MySPI_sdo(sdo),
    .Status_in(status),
    .Regs_out (regs_out),
    .Wr_strobe(strobe),
    .Busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] regs_m [NR];
  logic [7:0] tx   [16];
  logic [7:0] rx   [16];
  logic [7:0] rx_m [16];
  logic [7:0] exp_strobes [$];
  logic [7:0] strobe_log  [$];
  logic [7:0] dummy;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // every cycle with a nonzero strobe is logged, so a two-cycle pulse shows up as a duplicate entry
  always @(negedge clk) begin
    if (strobe != 8'h00) strobe_log.push_back(strobe);
  end

  function automatic logic [7:0] model_read(input int p);
    if (p >= NR) return 8'h00;
    if (p == 1) return status[p*8 +: 8];
    return regs_m[p];
  endfunction

  function automatic logic [63:0] model_pack();
    logic [63:0] r;
    for (int i = 0; i < NR; i++) r[i*8 +: 8] = regs_m[i];
    return r;
  endfunction

  task automatic model_frame(input logic [7:0] cmd, input int nw);
    int p;
    p = int'(cmd[6:0]);
    for (int k = 0; k < nw; k++) begin
      rx_m[k] = model_read(p);
      if (cmd[7] && p < NR && p != 1) begin
        regs_m[p] = tx[k];
        exp_strobes.push_back(8'(1 << p));
      end
      p = (p == NR - 1) ? 0 : (p + 1) % 128;
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int b = 7; b > 7 - nb; b--) begin
      sdi = w[b];
      tick(HALF);
      sck = 1'b1;
      r[b] = sdo;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input int nw, input int partial);
    strobe_log.delete();
    exp_strobes.delete();
    model_frame(cmd, nw);
    cs = 1'b0;
    tick(HALF);
    send_bits(cmd, 8, dummy);
    for (int k = 0; k < nw; k++) send_bits(tx[k], 8, rx[k]);
    if (partial > 0) send_bits(tx[nw], partial, dummy);
    tick(HALF);
    check_val({tag, "_busy_in_frame"}, 64'(busy), 64'd1);
    cs = 1'b1;
    tick(4);
    check_val({tag, "_busy_drop"}, 64'(busy), 64'd0);
    tick(6);
    for (int k = 0; k < nw; k++) check_val({tag, "_sdo_word"}, 64'(rx[k]), 64'(rx_m[k]));
    check_val({tag, "_regs"}, regs_out, model_pack());
    check_val({tag, "_strobe_count"}, 64'(strobe_log.size()), 64'(exp_strobes.size()));
    for (int k = 0; k < exp_strobes.size() && k < strobe_log.size(); k++)
      check_val({tag, "_strobe_mask"}, 64'(strobe_log[k]), 64'(exp_strobes[k]));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs_m[i] = 8'h00;
    tick(4);
    rst = 1'b0;
    tick(2);
    check_val("reset_regs", regs_out, 64'h0);
    check_val("reset_strobe", 64'(strobe), 64'h0);
    check_val("reset_busy", 64'(busy), 64'h0);
    check_val("reset_sdo", 64'(sdo), 64'h0);
    tick(6);

    tx[0] = 8'hA5;
    run_frame("wr_reg3", 8'h83, 1, 0);

    status[15:8] = 8'h5C;
    run_frame("rd_status1", 8'h01, 1, 0);
    tx[0] = 8'hFF;
    run_frame("wr_ro1", 8'h81, 1, 0);

    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    run_frame("burst_wrap", 8'h86, 3, 0);

    tx[0] = 8'hF0;
    run_frame("partial", 8'h82, 0, 5);

    run_frame("rd_7f_wrap", 8'h7F, 2, 0);

    // reset in the middle of a data word with CS held low
    strobe_log.delete();
    cs = 1'b0;
    tick(HALF);
    send_bits(8'h84, 8, dummy);
    send_bits(8'h77, 4, dummy);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    send_bits(8'h55, 8, dummy);
    send_bits(8'h66, 8, dummy);
    for (int i = 0; i < NR; i++) regs_m[i] = 8'h00;
    tick(HALF);
    check_val("midreset_regs", regs_out, 64'h0);
    check_val("midreset_busy", 64'(busy), 64'd0);
    check_val("midreset_strobes", 64'(strobe_log.size()), 64'd0);
    cs = 1'b1;
    tick(10);
    check_val("midreset_after_cs", 64'(strobe_log.size()), 64'd0);
    tx[0] = 8'h3C;
    run_frame("post_reset_wr", 8'h85, 1, 0);

    for (int it = 0; it < 20; it++) begin
      logic [7:0] cmd;
      int nw, partial;
      status = {$urandom(), $urandom()};
      cmd[6:0] = ($urandom_range(0, 9) == 9) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 7));
      cmd[7] = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 4);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k <= nw; k++) tx[k] = 8'($urandom());
      run_frame("random", cmd, nw, partial);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
